// File: rtl/ttl_mux_store_n_pkg.sv
// Shared definitions for the ttl_mux_store_n block.
//   state_t : control states of the scan/capture FSM (IDLE, SCAN, DONE)
//   clog2   : ceiling log2 used to size select and history index ports;
//             clog2(1) = 0, clog2(2) = 1, clog2(3) = 2, clog2(4) = 2, ...
package ttl_mux_store_n_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/ttl_hist_shift.sv
// History shift register: keeps the last DEPTH pushed words, newest at 0.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears all entries)
//   push       : shift all entries up by one and write din at entry 0
//   din        : word to push
//   idx        : read index (0 = newest)
//   dout       : entry[idx] when idx < count, else zero (combinational)
//   count      : number of valid entries, saturates at DEPTH
module ttl_hist_shift
    import ttl_mux_store_n_pkg::*;
#(
    parameter  int WIDTH = 4,
    parameter  int DEPTH = 4,
    localparam int IDXW  = clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic [IDXW-1:0]  idx,
    output logic [WIDTH-1:0] dout,
    output logic [IDXW-1:0]  count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [IDXW-1:0]  count_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            count_r <= '0;
        end else if (push) begin
            mem[0] <= din;
            // The oldest entry falls off the end.
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
            if (count_r != IDXW'(DEPTH)) begin
                count_r <= count_r + IDXW'(1);
            end
        end
    end

    // Entries beyond the valid count read as zero even if stale data exists.
    always_comb begin
        dout = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((idx == IDXW'(i)) && (idx < count_r)) begin
                dout = mem[i];
            end
        end
    end

    assign count = count_r;

endmodule

// File: rtl/ttl_mux_store_n.sv
// Multiplexed word store with auto-scan and capture history.
// A manual load captures channel ws; a scan captures channels 0..NUM_IN-1
// on consecutive cycles and then pulses scan_done. Every capture is also
// pushed into a DEPTH-entry history.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   ws         : manual channel select (values >= NUM_IN are ignored)
//   din        : packed channels, channel k at [k*WIDTH +: WIDTH]
//   load       : manual capture request (honoured only in IDLE)
//   scan_en    : start a scan (honoured only in IDLE, beats load)
//   hist_idx   : history read index, 0 = newest
//   q          : last captured word
//   hist_q     : history entry at hist_idx, zero when out of range
//   hist_cnt   : number of valid history entries
//   busy       : high while scanning
//   scan_done  : one-cycle pulse after the final scan capture
// DELAY is a simulation-only output delay and has no hardware meaning.
module ttl_mux_store_n
    import ttl_mux_store_n_pkg::*;
#(
    parameter  int WIDTH  = 4,
    parameter  int NUM_IN = 2,
    parameter  int DEPTH  = 4,
    parameter  int DELAY  = 0,
    localparam int SELW   = clog2(NUM_IN),
    localparam int IDXW   = clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [SELW-1:0]         ws,
    input  logic [NUM_IN*WIDTH-1:0] din,
    input  logic                    load,
    input  logic                    scan_en,
    input  logic [IDXW-1:0]         hist_idx,
    output logic [WIDTH-1:0]        q,
    output logic [WIDTH-1:0]        hist_q,
    output logic [IDXW-1:0]         hist_cnt,
    output logic                    busy,
    output logic                    scan_done
);

    localparam logic [SELW-1:0] LAST_CH = SELW'(NUM_IN - 1);

    generate
        if (WIDTH < 1 || WIDTH > 32 || NUM_IN < 2 || NUM_IN > 8 ||
            DEPTH < 1 || DEPTH > 16 || DELAY < 0) begin : g_bad_params
            $error("ttl_mux_store_n: parameter out of range");
        end
    endgenerate

    state_t            state;
    logic [SELW-1:0]   cnt;
    logic [WIDTH-1:0]  q_r;
    logic              busy_r;
    logic              done_r;

    logic [WIDTH-1:0]  chan [NUM_IN];
    logic [SELW-1:0]   sel;
    logic [WIDTH-1:0]  sel_word;
    logic              ws_ok;
    logic              push;

    for (genvar k = 0; k < NUM_IN; k++) begin : g_chan
        assign chan[k] = din[k*WIDTH +: WIDTH];
    end

    // ws can exceed NUM_IN-1 when NUM_IN is not a power of two.
    assign ws_ok = {1'b0, ws} < (SELW+1)'(NUM_IN);
    assign sel   = (state == ST_SCAN) ? cnt : ws;

    always_comb begin
        sel_word = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SELW'(k)) begin
                sel_word = chan[k];
            end
        end
    end

    // scan_en wins over load in IDLE; load is ignored outside IDLE.
    assign push = (state == ST_SCAN) ||
                  ((state == ST_IDLE) && !scan_en && load && ws_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            q_r    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            if (push) begin
                q_r <= sel_word;
            end
            done_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (scan_en) begin
                        state  <= ST_SCAN;
                        cnt    <= '0;
                        busy_r <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (cnt == LAST_CH) begin
                        state  <= ST_DONE;
                        cnt    <= '0;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                    end else begin
                        cnt <= cnt + SELW'(1);
                    end
                end
                ST_DONE: begin
                    // Always pass through IDLE so scans cannot chain.
                    state <= ST_IDLE;
                end
                default: begin
                    state  <= ST_IDLE;
                    cnt    <= '0;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    ttl_hist_shift #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_hist (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (sel_word),
        .idx   (hist_idx),
        .dout  (hist_q),
        .count (hist_cnt)
    );

    assign q         = q_r;
    assign busy      = busy_r;
    assign scan_done = done_r;

endmodule
